// File: rtl/fdt_search.sv
`default_nettype none
// ============================================================================
// fdt_search : first-level free directory, lowest non-full AT row per size
// Rev 1.0
// ============================================================================
module fdt_search #(
  parameter int FDT_DEPTH = 64,
  parameter int IDX_W     = 6,
  parameter int ID_W      = 8,
  parameter int SIZE_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req_valid,
  output logic              alloc_req_ready,
  input  logic [ID_W-1:0]   alloc_req_id,
  input  logic [SIZE_W-1:0] alloc_req_size,
  output logic              alloc_valid_at_out,
  output logic [ID_W-1:0]   alloc_id_at_out,
  output logic [IDX_W-1:0]  alloc_pos_at_out,
  output logic [SIZE_W-1:0] alloc_size_at_out,
  output logic              alloc_fail_valid,
  output logic [ID_W-1:0]   alloc_fail_id,
  input  logic              fdt_update_valid,
  input  logic [IDX_W-1:0]  fdt_update_idx,
  input  logic [3:0]        fdt_update_bit_sequence,
  input  logic              alloc_done,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic [SIZE_W-1:0]          size_q, size_d;
  logic [3:0][FDT_DEPTH-1:0]  full_q, full_d;
  logic                       valid_at_q, valid_at_d;
  logic [ID_W-1:0]            id_at_q, id_at_d;
  logic [IDX_W-1:0]           pos_at_q, pos_at_d;
  logic [SIZE_W-1:0]          size_at_q, size_at_d;
  logic                       fail_valid_q, fail_valid_d;
  logic [ID_W-1:0]            fail_id_q, fail_id_d;

  logic [FDT_DEPTH-1:0]       sel_vec;
  logic                       search_found;
  logic [IDX_W-1:0]           search_pos;
  logic                       upd_in_range;

  generate
    if (FDT_DEPTH == (1 << IDX_W)) begin : g_idx_full
      assign upd_in_range = 1'b1;
    end else begin : g_idx_partial
      assign upd_in_range = ({{(32-IDX_W){1'b0}}, fdt_update_idx} < FDT_DEPTH);
    end
  endgenerate

  always_comb begin
    full_d = full_q;
    if (fdt_update_valid && upd_in_range) begin
      for (int s = 0; s < 4; s++) begin
        full_d[s][fdt_update_idx] = fdt_update_bit_sequence[s];
      end
    end
  end

  // Encoder sees the directory as registered; a same-cycle update is not visible.
  always_comb begin
    sel_vec      = full_q[size_q];
    search_found = 1'b0;
    search_pos   = '0;
    for (int i = FDT_DEPTH - 1; i >= 0; i--) begin
      if (!sel_vec[i]) begin
        search_found = 1'b1;
        search_pos   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    size_d       = size_q;
    valid_at_d   = 1'b0;
    id_at_d      = '0;
    pos_at_d     = '0;
    size_at_d    = '0;
    fail_valid_d = 1'b0;
    fail_id_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (alloc_req_valid) begin
          id_d    = alloc_req_id;
          size_d  = alloc_req_size;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        state_d = ST_ISSUE;
        if (search_found) begin
          valid_at_d = 1'b1;
          id_at_d    = id_q;
          pos_at_d   = search_pos;
          size_at_d  = size_q;
        end else begin
          fail_valid_d = 1'b1;
          fail_id_d    = id_q;
        end
      end
      ST_ISSUE: state_d = valid_at_q ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (alloc_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      size_q       <= '0;
      full_q       <= '0;
      valid_at_q   <= 1'b0;
      id_at_q      <= '0;
      pos_at_q     <= '0;
      size_at_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      size_q       <= size_d;
      full_q       <= full_d;
      valid_at_q   <= valid_at_d;
      id_at_q      <= id_at_d;
      pos_at_q     <= pos_at_d;
      size_at_q    <= size_at_d;
      fail_valid_q <= fail_valid_d;
      fail_id_q    <= fail_id_d;
    end
  end

  assign alloc_req_ready    = (state_q == ST_IDLE);
  assign busy               = (state_q != ST_IDLE);
  assign alloc_valid_at_out = valid_at_q;
  assign alloc_id_at_out    = id_at_q;
  assign alloc_pos_at_out   = pos_at_q;
  assign alloc_size_at_out  = size_at_q;
  assign alloc_fail_valid   = fail_valid_q;
  assign alloc_fail_id      = fail_id_q;

endmodule
`default_nettype wire

// File: doc/fdt_search.md
Name: fdt_search

Overview:
- First-level directory (FDT) of the allocator, directly upstream of the AND-tree stage.
- Holds one "line full" bit per AND-tree row per size class. Bit = 1 means that 64-bit AT line has no zero (free) slot left for that size.
- Accepts allocation requests, finds the lowest-index non-full row for the requested size, and issues that row to the AND-tree.
- Absorbs the FDT update stream from the AND-tree, and serialises allocations so that a line is never issued twice before its update lands.

Parameters:
- FDT_DEPTH, 64, number of AT rows tracked per size class (≤ 2^IDX_W).
- IDX_W, 6, row index width; equals the AT tree index width.
- ID_W, 8, request ID width.
- SIZE_W, 2, size-type width. Encoding: 0 = 512, 1 = 1K, 2 = 2K, 3 = 4K.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req_valid  in  1  upstream request valid
- alloc_req_ready  out  1  block can accept a request
- alloc_req_id  in  ID_W  request ID
- alloc_req_size  in  SIZE_W  aligned size type
- alloc_valid_at_out  out  1  issue to AND-tree, one-cycle pulse
- alloc_id_at_out  out  ID_W  ID of the issued request
- alloc_pos_at_out  out  IDX_W  AT row to read
- alloc_size_at_out  out  SIZE_W  size of the issued request
- alloc_fail_valid  out  1  one-cycle pulse: no non-full row for this size
- alloc_fail_id  out  ID_W  ID of the failed request
- fdt_update_valid  in  1  update from AND-tree
- fdt_update_idx  in  IDX_W  row being updated
- fdt_update_bit_sequence  in  4  {4K, 2K, 1K, 512} full bits for that row
- alloc_done  in  1  downstream pulse: the issued allocation's AT/FDT update has completed
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - All 4×FDT_DEPTH full bits = 0.
  - FSM = IDLE.
  - alloc_req_ready = 1.
  - All other outputs = 0.
- FSM states: IDLE, SEARCH, ISSUE, WAIT.
- IDLE: ready = 1.
  - On valid & ready, latch id and size, go to SEARCH.
- SEARCH: ready = 0.
  - Select the full vector for the latched size.
  - Priority-encode its lowest-index 0 bit over rows 0..FDT_DEPTH-1.
  - Register the result (pos + found flag) and go to ISSUE.
  - The encoder reads register contents as they stand at the start of the cycle; an update written that same cycle is not seen.
- ISSUE: exactly one of the following pulses for this one cycle; outputs are registered.
  - Found: alloc_valid_at_out = 1 with latched id/size and pos; next state WAIT.
  - Not found: alloc_fail_valid = 1 with alloc_fail_id = latched id; next state IDLE.
  - alloc_*_at_out are 0 whenever alloc_valid_at_out = 0. alloc_fail_id is 0 whenever alloc_fail_valid = 0.
- WAIT: ready = 0.
  - On alloc_done go to IDLE; ready rises the following cycle.
  - alloc_done is ignored in every state other than WAIT.
- Latency: request accepted at edge N → alloc_valid_at_out (or alloc_fail_valid) high during cycle N+2.
  - Minimum spacing between accepts: 3 cycles plus the WAIT time.
- Updates:
  - On fdt_update_valid, write all 4 bits of row fdt_update_idx on that edge, in any state.
  - Idx ≥ FDT_DEPTH: ignored.
  - Back-to-back updates are legal, one per cycle; the last write wins.
- Reset mid-operation returns to IDLE immediately, with no pulse emitted.
  - Any pending alloc is dropped.
- alloc_req_valid while ready = 0: not accepted; upstream holds the request.
- busy = (state != IDLE).

Test Plan:
- Reset, then request id=0x11 size=0 → in cycle N+2: alloc_valid_at_out=1, pos=0, size=0, id=0x11; busy=1 until alloc_done; ready=1 the cycle after alloc_done.
- Update idx=0 bits=4'b0001, then request size=0 → pos=1. Request size=1 after alloc_done → pos=0.
- Update idx=0..63 with bit3=1, then request size=3 id=0x2A → alloc_fail_valid=1, fail_id=0x2A, no alloc_valid_at_out; returns to IDLE without alloc_done.
- Update idx=0 bits=0001 in the same cycle as the SEARCH state for size 0 → pos=0 (update not seen). Next request → pos=1.
- alloc_done pulsed in IDLE, and alloc_req_valid held while busy → no state change; the held request is accepted only after WAIT exits.
- Assert rst_n=0 in WAIT with row 5 full bits set → all bits clear, ready=1, a new size-2 request yields pos=0.
